wave_capture: RTL and testbench

- Upstream capture stage for the oscilloscope display.
- Watches the 16-bit signed audio sample stream and arms on a rising zero crossing.
- Writes 256 consecutive samples, converted to 8-bit offset-binary, into the half of the 512-entry sample RAM that the display is not reading.
- Flips read_index during display idle time, so the display always reads a complete, stable buffer.

---
 rtl/wave_capture.sv | 108 ++++++++++
 tb/tb_wave_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of 256 offset-binary samples into the idle half of a double-buffered sample RAM.
// Optional auto-trigger after TIMEOUT_SAMPLES armed strobes: define TRIGGER_TIMEOUT_EN.
module wave_capture #(
  parameter int SAMPLE_W        = 16,
  parameter int DEPTH_LOG2      = 8,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  new_sample_ready,
  input  logic [SAMPLE_W-1:0]   new_sample_in,
  input  logic                  wave_display_idle,
  output logic [DEPTH_LOG2:0]   write_address,
  output logic                  write_enable,
  output logic [7:0]            write_sample,
  output logic                  read_index
);

  // state  | meaning
  // ARMED  | watching for a negative -> non-negative crossing
  // ACTIVE | writing one converted sample per strobe into half ~read_index
  // WAIT   | capture complete, waiting for display idle to swap halves
  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] count;
  logic                  prev_neg;

  logic       sample_msb;
  logic [7:0] sample_conv;
  logic       crossing;
  logic       timeout_hit;
  logic       unused_low_bits;

  assign sample_msb      = new_sample_in[SAMPLE_W-1];
  assign sample_conv     = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
  assign crossing        = prev_neg & ~sample_msb;
  assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];

`ifdef TRIGGER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_SAMPLES - 1);

  // Down-counter of remaining armed strobes; terminal count forces a trigger.
  logic [TO_W-1:0] to_cnt;
  assign timeout_hit = (to_cnt == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARMED;
      count         <= '0;
      prev_neg      <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
`ifdef TRIGGER_TIMEOUT_EN
      to_cnt        <= TO_LOAD;
`endif
    end else begin
      write_enable <= 1'b0;
      case (state)
        ARMED: begin
          if (new_sample_ready) begin
            prev_neg <= sample_msb;
            if (crossing || timeout_hit) begin
              state <= ACTIVE;
              count <= '0;
            end
`ifdef TRIGGER_TIMEOUT_EN
            else begin
              to_cnt <= to_cnt - TO_W'(1);
            end
`endif
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= sample_conv;
            count         <= count + DEPTH_LOG2'(1);
            if (count == '1) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            prev_neg   <= 1'b0;
            state      <= ARMED;
`ifdef TRIGGER_TIMEOUT_EN
            to_cnt     <= TO_LOAD;
`endif
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Randomized scoreboard bench for wave_capture with a behavioural capture model.
module tb_wave_capture;

  logic        clk;
  logic        reset_n;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode of the capture process, which half is displayed, how many samples so far.
  localparam int M_ARMED = 0;
  localparam int M_CAPT  = 1;
  localparam int M_WAIT  = 2;
  int   m_mode;
  int   m_half;
  int   m_written;
  int   m_armed_strobes;
  bit   m_prev_neg;
  int   m_pushes;
  int   dut_writes;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_ARMED;
    m_half = 0;
    m_written = 0;
    m_armed_strobes = 0;
    m_prev_neg = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit s, input logic [15:0] v, input bit idle);
    int addr;
    int conv;
    bit trig;
    if (m_mode == M_WAIT) begin
      if (idle) begin
        m_half = 1 - m_half;
        m_mode = M_ARMED;
        m_prev_neg = 1'b0;
        m_armed_strobes = 0;
      end
    end else if (m_mode == M_CAPT) begin
      if (s) begin
        addr = (m_half == 0 ? 256 : 0) + m_written;
        conv = ((int'(v) / 256) + 128) % 256;
        exp_q.push_back({9'(addr), 8'(conv)});
        m_pushes++;
        m_written++;
        if (m_written == 256) m_mode = M_WAIT;
      end
    end else if (s) begin
      m_armed_strobes++;
      trig = m_prev_neg && !v[15];
`ifdef TRIGGER_TIMEOUT_EN
      if (m_armed_strobes == 1024) trig = 1'b1;
`endif
      if (trig) begin
        m_mode = M_CAPT;
        m_written = 0;
      end
      m_prev_neg = v[15];
    end
  endtask

  task automatic step(input bit s, input logic [15:0] v, input bit idle);
    @(negedge clk);
    new_sample_ready  = s;
    new_sample_in     = v;
    wave_display_idle = idle;
    model_step(s, v, idle);
  endtask

  task automatic trigger();
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0200, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_write_enable", int'(write_enable), 0);
    check("rst_write_address", int'(write_address), 0);
    check("rst_write_sample", int'(write_sample), 0);
    check("rst_read_index", int'(read_index), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compares every DUT write against the scoreboard and tracks read_index.
  always begin
    logic [16:0] e;
    @(posedge clk);
    #1;
    if (reset_n) begin
      check("read_index", int'(read_index), m_half);
      if (write_enable) begin
        dut_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_address", int'(write_address), int'(e[16:8]));
          check("write_sample", int'(write_sample), int'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int p0;
    reset_n = 1'b0;
    new_sample_ready = 1'b0;
    new_sample_in = '0;
    wave_display_idle = 1'b0;
    m_pushes = 0;
    dut_writes = 0;
    model_reset();
    #1;
    check("por_write_enable", int'(write_enable), 0);
    check("por_write_address", int'(write_address), 0);
    check("por_read_index", int'(read_index), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Non-negative input never arms a capture.
    for (int i = 0; i < 10; i++) step(1'b1, 16'h1000, 1'b1);
    check("no_write_positive_only", dut_writes, 0);

    // Basic capture: ramp with random gaps, then hold WAIT with display busy, then swap.
    trigger();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 16'(i << 8), 1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0, 16'($urandom), 1'b1);
    end
    for (int i = 0; i < 50; i++) step(i[0], 16'($urandom), 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    check("capture1_writes", dut_writes, 256);

    // Back-to-back capture into half 0, extra strobes afterwards must be ignored.
    trigger();
    for (int i = 0; i < 256; i++) step(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("capture2_writes", dut_writes, 512);
    step(1'b0, 16'h0000, 1'b1);

    // Reset mid-capture, then a fresh capture starting with the conversion corner cases.
    trigger();
    for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b0);
    async_reset();
    trigger();
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0);
    for (int i = 4; i < 256; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0));

    // Drive into ARMED, then constant DC input.
    for (int i = 0; i < 1000 && m_mode != M_ARMED; i++) step(1'b1, 16'($urandom), 1'b1);
    check("reached_armed", m_mode, M_ARMED);
    w0 = dut_writes;
    p0 = m_pushes;
    for (int i = 0; i < 5000; i++) step(1'b1, 16'h0400, 1'b1);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
`ifdef TRIGGER_TIMEOUT_EN
    check("timeout_writes", dut_writes - w0, m_pushes - p0);
    check("timeout_fired", int'((dut_writes - w0) > 0), 1);
`else
    check("dc_no_writes", dut_writes - w0, 0);
`endif

    check("pending_expected", exp_q.size(), 0);
    check("total_writes", dut_writes, m_pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
